// File: rtl/bram_seq_ctrl_pkg.sv
// Shared encodings for the block-RAM sequencer: command opcodes and FSM states.
package bram_seq_ctrl_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_READ  = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_READ,
    ST_FIN
  } state_t;

endpackage

// File: rtl/bram_seq_fifo2.sv
// Two-entry FIFO that buffers RAM read data ahead of the stream sink.
module bram_seq_fifo2 #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_push  = i_push & (~o_full | i_pop);
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rp];
  assign o_empty = (r_cnt == 2'd0);
  assign o_full  = (r_cnt == 2'd2);
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

// File: rtl/bram_seq_ctrl.sv
// Command sequencer for a single-port sync-read block RAM: clear, stream-load and stream-read.
module bram_seq_ctrl
  import bram_seq_ctrl_pkg::*;
#(
  parameter int unsigned N = 13,
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_base,
  input  logic [N:0]   cmd_len,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] mem_addr,
  output logic         mem_we,
  output logic [W-1:0] mem_din,
  input  logic [W-1:0] mem_dout,
  output logic         mem_clear
);

  localparam int unsigned RW = N + 1;

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_ptr;
  logic [RW-1:0] r_rem;
  logic          r_inflight;
  logic          w_accept;
  logic          w_issue;
  logic          w_step;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [1:0]    w_count;
  logic [2:0]    w_credit;
  logic [W-1:0]  w_head;

  assign w_accept  = cmd_valid & cmd_ready;
  assign w_pop     = m_valid & m_ready;
  assign m_valid   = ~w_empty;
  assign m_data    = w_head;
  assign w_step    = mem_we | w_issue;
  assign mem_clear = 1'b0;
  // Slots committed after this cycle; a same-cycle pop frees one, which keeps 1 word/cycle.
  assign w_credit  = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    s_ready   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    w_issue   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            w_next = ST_FIN;
          end else begin
            unique case (op_t'(cmd_op))
              OP_CLEAR: w_next = ST_CLEAR;
              OP_LOAD:  w_next = ST_LOAD;
              OP_READ:  w_next = ST_READ;
              default:  w_next = ST_FIN;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = r_ptr;
        if (r_rem <= RW'(1)) w_next = ST_FIN;
      end
      ST_LOAD: begin
        s_ready = (r_rem != '0);
        if (s_valid && (r_rem != '0)) begin
          mem_we   = 1'b1;
          mem_addr = r_ptr;
          mem_din  = s_data;
          if (r_rem == RW'(1)) w_next = ST_FIN;
        end else if (r_rem == '0) begin
          w_next = ST_FIN;
        end
      end
      ST_READ: begin
        if ((r_rem != '0) && (w_credit < 3'd2) && !(w_full && !w_pop)) begin
          w_issue  = 1'b1;
          mem_addr = r_ptr;
        end
        if ((r_rem == '0) && !r_inflight && w_empty) w_next = ST_FIN;
      end
      ST_FIN: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_ptr <= cmd_base;
        r_rem <= cmd_len;
      end else if (w_step) begin
        r_ptr <= r_ptr + N'(1);
        r_rem <= r_rem - RW'(1);
      end
    end
  end

  // RAM data for a read issued last cycle lands in the FIFO now.
  bram_seq_fifo2 #(.W(W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_din   (mem_dout),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_bram_seq_ctrl.sv
// Directed bench for bram_seq_ctrl paired with a behavioural sync-read RAM.
module tb_bram_seq_ctrl;
  import bram_seq_ctrl_pkg::*;

  localparam int unsigned N = 13;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_base;
  logic [N:0]   cmd_len;
  logic         s_valid, s_ready;
  logic [W-1:0] s_data;
  logic         m_valid, m_ready;
  logic [W-1:0] m_data;
  logic         busy, done;
  logic [N-1:0] mem_addr;
  logic         mem_we;
  logic [W-1:0] mem_din;
  logic [W-1:0] mem_dout;
  logic         mem_clear;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [W-1:0] ram [2**N];
  logic [N-1:0] wl_addr [32768];
  logic [W-1:0] wl_data [32768];
  int unsigned  wcnt = 0;
  logic [W-1:0] rd_buf [64];

  always #5 clk = ~clk;

  bram_seq_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_clear(mem_clear)
  );

  // RAM model: registered read of the old word, write on mem_we; also logs every write.
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]       <= mem_din;
      wl_addr[wcnt[14:0]] <= mem_addr;
      wl_data[wcnt[14:0]] <= mem_din;
      wcnt                <= wcnt + 1;
    end
    mem_dout <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [N-1:0] base, input logic [N:0] len);
    int c = 0;
    while (!cmd_ready && c < 50) begin @(negedge clk); c++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (!done && c < budget) begin @(negedge clk); c++; end
    chk(tag, done, 1);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [N-1:0] base, input logic [N:0] len, input logic [W-1:0] d0,
                         input bit gaps, input int n_send);
    int i = 0;
    int c = 0;
    send_cmd(OP_LOAD, base, len);
    while (i < n_send && c < 200) begin
      s_valid = !(gaps && (c % 3 == 1));
      s_data  = d0 + 16'(i);
      #1;
      if (s_valid && s_ready) i++;
      @(negedge clk);
      c++;
    end
    s_valid = 1'b0;
    chk("load_words", i, n_send);
  endtask

  task automatic do_read(input logic [N-1:0] base, input logic [N:0] len, output int nw);
    int c = 0;
    nw = 0;
    m_ready = 1'b1;
    send_cmd(OP_READ, base, len);
    while (!done && c < 300) begin
      if (m_valid && m_ready && nw < 64) begin rd_buf[nw] = m_data; nw++; end
      @(negedge clk);
      c++;
    end
    chk("read_done", done, 1);
    @(negedge clk);
  endtask

  initial begin
    int nw, k, last, cnt, w0, first_v, nvalid, done_idx;
    bit stalled;
    logic [W-1:0] held;
    logic [W-1:0] exp_v;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_base = '0; cmd_len = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_clear", mem_clear, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Pre-fill so the clear has something to erase.
    do_load(13'd0, 14'd4, 16'h55A0, 1'b0, 4);
    wait_done("preload_done", 10);

    // 1: full-RAM clear
    w0 = int'(wcnt);
    send_cmd(OP_CLEAR, 13'd0, 14'd8192);
    k = 0; cnt = 0; last = -1;
    while (!done && k < 9000) begin
      if (mem_we) begin cnt++; last = k; end
      @(negedge clk);
      k++;
    end
    chk("clr_we_cycles", cnt, 8192);
    chk("clr_done_at", k, last + 1);
    chk("clr_log_cnt", int'(wcnt) - w0, 8192);
    @(negedge clk);
    do_read(13'd0, 14'd4, nw);
    chk("clr_rd_cnt", nw, 4);
    for (int i = 0; i < 4; i++) chk("clr_rd_data", rd_buf[i], 0);

    // 2: wrapping load with gaps, then read back
    w0 = int'(wcnt);
    do_load(13'd8190, 14'd4, 16'h00A1, 1'b1, 4);
    wait_done("wrap_load_done", 10);
    chk("wrap_a0", wl_addr[w0],   13'd8190);
    chk("wrap_a1", wl_addr[w0+1], 13'd8191);
    chk("wrap_a2", wl_addr[w0+2], 13'd0);
    chk("wrap_a3", wl_addr[w0+3], 13'd1);
    chk("wrap_d0", wl_data[w0],   16'h00A1);
    chk("wrap_d3", wl_data[w0+3], 16'h00A4);
    do_read(13'd8190, 14'd4, nw);
    chk("wrap_rd_cnt", nw, 4);
    for (int i = 0; i < 4; i++) chk("wrap_rd_data", rd_buf[i], 16'h00A1 + 16'(i));

    // 3: read under random backpressure
    do_load(13'd100, 14'd16, 16'h1000, 1'b0, 16);
    wait_done("bp_load_done", 10);
    m_ready = 1'b0;
    send_cmd(OP_READ, 13'd100, 14'd16);
    k = 0; cnt = 0; stalled = 1'b0; held = '0;
    while (k < 16 && cnt < 400) begin
      if (stalled) begin
        chk("bp_hold_valid", m_valid, 1);
        chk("bp_hold_data", m_data, held);
      end
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (m_valid && m_ready) begin
        exp_v = 16'h1000 + 16'(k);
        chk("bp_order", m_data, exp_v);
        k++;
        stalled = 1'b0;
      end else begin
        stalled = m_valid;
        held    = m_data;
      end
      @(negedge clk);
      cnt++;
    end
    chk("bp_words", k, 16);
    m_ready = 1'b1;
    wait_done("bp_done", 10);
    chk("bp_no_extra", m_valid, 0);

    // 4: full-rate read latency and throughput
    m_ready = 1'b1;
    send_cmd(OP_READ, 13'd100, 14'd8);
    first_v = -1; nvalid = 0; done_idx = -1;
    for (int i = 0; i < 16; i++) begin
      if (m_valid) begin
        if (first_v < 0) first_v = i;
        chk("rate_data", m_data, 16'h1000 + 16'(nvalid));
        nvalid++;
      end
      if (done && done_idx < 0) done_idx = i;
      @(negedge clk);
    end
    chk("rate_first", first_v, 2);
    chk("rate_count", nvalid, 8);
    chk("rate_done_after", (done_idx >= first_v + 8) && (done_idx <= first_v + 10), 1);

    // 5: zero length, reserved op, command while busy
    w0 = int'(wcnt);
    s_valid = 1'b1; s_data = 16'hBEEF;
    send_cmd(OP_LOAD, 13'd5, 14'd0);
    chk("len0_done", done, 1);
    chk("len0_we", mem_we, 0);
    chk("len0_s_ready", s_ready, 0);
    @(negedge clk);
    chk("len0_idle", busy, 0);
    chk("len0_done_pulse", done, 0);
    send_cmd(2'b11, 13'd7, 14'd5);
    chk("rsvd_done", done, 1);
    chk("rsvd_we", mem_we, 0);
    @(negedge clk);
    chk("rsvd_idle", busy, 0);
    s_valid = 1'b0;
    chk("noop_writes", int'(wcnt) - w0, 0);
    w0 = int'(wcnt);
    send_cmd(OP_CLEAR, 13'd200, 14'd8);
    cmd_valid = 1'b1; cmd_op = OP_READ; cmd_base = 13'd0; cmd_len = 14'd4;
    for (int i = 0; i < 3; i++) begin
      chk("busy_no_ready", cmd_ready, 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wait_done("busy_clr_done", 20);
    for (int i = 0; i < 3; i++) begin
      chk("busy_ignored", busy, 0);
      @(negedge clk);
    end
    chk("busy_clr_writes", int'(wcnt) - w0, 8);

    // 6: reset in the middle of a load, then a normal clear
    w0 = int'(wcnt);
    do_load(13'd300, 14'd10, 16'h2000, 1'b0, 3);
    chk("mid_busy", busy, 1);
    s_valid = 1'b1; s_data = 16'h7777;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_done", done, 0);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_din", mem_din, 0);
    chk("arst_m_data", m_data, 0);
    @(negedge clk);
    rst_n = 1'b1; s_valid = 1'b0;
    chk("partial_writes", int'(wcnt) - w0, 3);
    @(negedge clk);
    w0 = int'(wcnt);
    send_cmd(OP_CLEAR, 13'd300, 14'd4);
    wait_done("post_rst_done", 10);
    chk("post_rst_writes", int'(wcnt) - w0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_addr", wl_addr[w0+i], 13'd300 + 13'(i));
      chk("post_rst_data", wl_data[w0+i], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
